// File: rtl/instr_fetch_pkg.sv
// Shared types and field helpers for the instruction fetch memory.
package instr_fetch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned OP_W     = 2;
  localparam int unsigned FLD_W    = 5;
  localparam int unsigned FIELDS_W = OP_W + 6 * FLD_W;

  // Decode-stage view of the low FIELDS_W bits of an instruction word, MSB first.
  typedef struct packed {
    logic [OP_W-1:0]  opcode;
    logic [FLD_W-1:0] f5;
    logic [FLD_W-1:0] f4;
    logic [FLD_W-1:0] f3;
    logic [FLD_W-1:0] f2;
    logic [FLD_W-1:0] f1;
    logic [FLD_W-1:0] f0;
  } instr_fields_t;

  function automatic instr_fields_t split_fields(input logic [FIELDS_W-1:0] w);
    return instr_fields_t'(w);
  endfunction

  function automatic logic [OP_W-1:0] get_opcode(input logic [FIELDS_W-1:0] w);
    return w[FIELDS_W-1 -: OP_W];
  endfunction

endpackage

// File: rtl/instr_ram_sp.sv
// Single-port RAM: synchronous write, registered read with a resettable output register.
module instr_ram_sp #(
  parameter int unsigned M      = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [M-1:0]      wdata,
  output logic [M-1:0]      rdata
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [M-1:0]     mem [DEPTH];
  logic [IDX_W-1:0] idx;

  assign idx = IDX_W'(addr);

  // Storage array carries no reset so it maps onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/instr_fetch_mem.sv
// Loadable instruction memory with a PC sequencer (start/stall/jump/halt) feeding decode.
module instr_fetch_mem
  import instr_fetch_pkg::*;
#(
  parameter int unsigned M      = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [M-1:0]      load_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              stall,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic [M-1:0]      instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              wrapped,
  output logic              busy
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc_n, instr_pc_n, ram_addr;
  logic              instr_valid_n, wrapped_n, ram_we, ram_re, load_in_range;

  function automatic logic [ADDR_W-1:0] mod_depth(input logic [ADDR_W-1:0] a);
    return ADDR_W'(32'(a) % DEPTH);
  endfunction

  assign load_in_range = ({1'b0, load_addr} < (ADDR_W + 1)'(DEPTH));

  instr_ram_sp #(
    .M      (M),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (load_data),
    .rdata (instr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      instr_valid <= 1'b0;
      instr_pc    <= '0;
      wrapped     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr_valid <= instr_valid_n;
      instr_pc    <= instr_pc_n;
      wrapped     <= wrapped_n;
      busy        <= (state_n == RUN);
    end
  end

  // Priority in RUN: halt > jump > stall > fetch. A stall leaves the RAM read disabled.
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    instr_valid_n = instr_valid;
    instr_pc_n    = instr_pc;
    wrapped_n     = 1'b0;
    ram_we        = 1'b0;
    ram_re        = 1'b0;
    ram_addr      = load_addr;
    unique case (state)
      IDLE: begin
        ram_we = load_en && load_in_range;
        if (start) begin
          state_n       = RUN;
          pc_n          = mod_depth(start_addr);
          instr_valid_n = 1'b0;
        end
      end
      RUN: begin
        ram_addr = pc;
        if (halt) begin
          state_n       = IDLE;
          instr_valid_n = 1'b0;
        end else if (jump_en) begin
          pc_n          = mod_depth(jump_addr);
          instr_valid_n = 1'b0;
        end else if (!stall) begin
          ram_re        = 1'b1;
          instr_pc_n    = pc;
          instr_valid_n = 1'b1;
          if (pc == ADDR_W'(DEPTH - 1)) begin
            pc_n      = '0;
            wrapped_n = 1'b1;
          end else begin
            pc_n = pc + ADDR_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/instr_fetch_mem.md
Name: instr_fetch_mem

Overview:
- Parametrised instruction memory with a built-in fetch sequencer; next generation of the team's fixed 32x32 asynchronous-read instruction ROM.
- Adds a runtime program-load port, a registered synchronous read, a PC with stall/jump/halt control, and wrap detection.
- Sits between the program loader (testbench or boot logic) and the decode stage of the small datapath CPU.

Parameters:
- M, 32, instruction word width in bits; must be at least OP_W + 6*FLD_W.
- ADDR_W, 5, PC/address width in bits.
- DEPTH, 2**ADDR_W, number of words; must be at most 2**ADDR_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- load_en  in  1  write strobe for program load; honoured in IDLE only.
- load_addr  in  ADDR_W  write address.
- load_data  in  M  write data.
- start  in  1  single-cycle pulse; IDLE->RUN, fetch begins at start_addr.
- start_addr  in  ADDR_W  initial PC.
- stall  in  1  hold PC and output registers.
- jump_en  in  1  redirect PC to jump_addr.
- jump_addr  in  ADDR_W  redirect target.
- halt  in  1  RUN->IDLE.
- pc  out  ADDR_W  address of the next fetch.
- instr  out  M  registered instruction.
- instr_valid  out  1  instr holds a valid fetched word.
- instr_pc  out  ADDR_W  address instr was fetched from.
- wrapped  out  1  one-cycle pulse when PC wraps DEPTH-1 -> 0.
- busy  out  1  high in RUN.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; pc=0, instr=0, instr_valid=0, instr_pc=0, wrapped=0, busy=0.
- Memory array is not reset. Its contents are undefined until loaded.
- States: IDLE and RUN.
- IDLE:
  - load_en writes mem[load_addr] <= load_data at the clock edge.
  - Writes with load_addr >= DEPTH are dropped.
  - start moves to RUN with pc <= start_addr and instr_valid <= 0.
  - If load_en and start occur together, the write completes and RUN begins.
- RUN: busy=1; load_en is ignored; start is ignored.
- RUN, normal fetch (no stall, jump or halt), cycle t with pc=p, next edge:
  - instr <= mem[p], instr_pc <= p, instr_valid <= 1.
  - pc <= p+1; latency is one cycle.
- Wrap: when p = DEPTH-1, pc <= 0 and wrapped pulses for one cycle.
- Stall: pc, instr, instr_pc and instr_valid are all held. No read side-effects occur.
- Jump:
  - pc <= jump_addr, instr_valid <= 0 (one bubble), then fetch resumes from jump_addr.
  - Jump has priority over stall.
  - jump_addr >= DEPTH is reduced modulo DEPTH.
- Halt:
  - Highest priority in RUN.
  - Next edge: state=IDLE, instr_valid <= 0, pc held, instr/instr_pc held.
- Reset mid-RUN: immediate return to reset values. Memory contents are kept.
- Address arithmetic is unsigned modulo DEPTH. When DEPTH = 2**ADDR_W this is natural overflow.

Decomposition:
- Package instr_fetch_pkg holds:
  - state enum {IDLE, RUN};
  - OP_W=2 and FLD_W=5;
  - field slice helpers for {opcode, f5..f0}, MSB first.
- One sub-module, instr_ram_sp: single-port synchronous-write, registered-read RAM (M, DEPTH).
  - The sequencer drives its address mux: load_addr in IDLE, pc in RUN.

Test Plan:
- Load and run: load mem[0..3]=32'h1111_0000+i, start with start_addr=0, no stall. instr_valid rises 1 cycle after start; instr = 0x11110000, 0x11110001, 0x11110002, 0x11110003 on consecutive cycles; instr_pc = 0, 1, 2, 3.
- Stall: stall during cycle 3 for 2 cycles. instr=0x11110001 and pc=2 are held both cycles; the sequence resumes with 0x11110002 and no word is lost or duplicated.
- Jump versus stall: jump_en=1, jump_addr=20, stall=1 in the same cycle. The next cycle has instr_valid=0 and pc=20; the following cycle has instr=mem[20] and instr_pc=20.
- Wrap: start_addr=30, DEPTH=32. instr_pc = 30, 31, 0, 1; wrapped pulses exactly once, on the edge where pc goes 31->0.
- Load ignored in RUN and halt: load_en with mem[5]=0xDEAD_BEEF during RUN leaves mem[5] unchanged. Halt gives busy=0 and instr_valid=0 on the next edge. A load in IDLE then writes mem[5], and a restart at 5 fetches 0xDEADBEEF.
- Asynchronous reset mid-RUN: assert rst between clock edges. All outputs are zero immediately. After deassertion and start=0, mem[0] still holds 0x11110000.
